// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues product/change requests from the vending FSM
// and runs the product motor and change hopper one at a time, with
// drop-sensor completion, run timeouts and a forced gap between dispenses.
// Optional build macro SENSE_SYNC_EN: pass the drop sensors through
// 2-flop synchronizers (adds 2 cycles of detection latency; the timeout
// windows are not stretched).
module vend_dispense_ctrl #(
    parameter int PEND_W    = 3,
    parameter int MOTOR_TO  = 16,
    parameter int HOPPER_TO = 12,
    parameter int GAP_CYC   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p_out,
    input  logic c_out,
    input  logic prod_sense,
    input  logic coin_sense,
    input  logic fault_clr,
    output logic motor_on,
    output logic hopper_on,
    output logic prod_done,
    output logic chg_done,
    output logic busy,
    output logic fault,
    output logic overflow
);

    localparam int TMR_MAX = (MOTOR_TO > HOPPER_TO) ? MOTOR_TO : HOPPER_TO;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [TMR_W-1:0]  MOTOR_LAST  = TMR_W'(MOTOR_TO - 1);
    localparam logic [TMR_W-1:0]  HOPPER_LAST = TMR_W'(HOPPER_TO - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE     = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROD,
        S_CHG,
        S_GAP,
        S_FAULT
    } state_t;

    state_t            state;
    logic [PEND_W-1:0] prod_pend;
    logic [PEND_W-1:0] chg_pend;
    logic [TMR_W-1:0]  timer;
    logic [GAP_W-1:0]  gap_cnt;

    logic ps;
    logic cs;

`ifdef SENSE_SYNC_EN
    logic [1:0] ps_sync;
    logic [1:0] cs_sync;

    // Two-stage synchronizers for the asynchronous drop sensors
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_sync <= 2'b00;
            cs_sync <= 2'b00;
        end else begin
            ps_sync <= {ps_sync[0], prod_sense};
            cs_sync <= {cs_sync[0], coin_sense};
        end
    end

    assign ps = ps_sync[1];
    assign cs = cs_sync[1];
`else
    assign ps = prod_sense;
    assign cs = coin_sense;
`endif

    // Dispatch decisions are taken from the registered counts, product first
    logic p_dec;
    logic c_dec;
    logic p_full;
    logic c_full;

    assign p_dec  = (state == S_IDLE) && (prod_pend != '0);
    assign c_dec  = (state == S_IDLE) && (prod_pend == '0) && (chg_pend != '0);
    // A counter at max that is being dispatched this cycle can still accept
    assign p_full = (prod_pend == PEND_MAX) && !p_dec;
    assign c_full = (chg_pend == PEND_MAX) && !c_dec;

    // Request capture: runs in every state, saturates and flags overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_pend <= '0;
            chg_pend  <= '0;
            overflow  <= 1'b0;
        end else begin
            case ({p_out && !p_full, p_dec})
                2'b10:   prod_pend <= prod_pend + PEND_ONE;
                2'b01:   prod_pend <= prod_pend - PEND_ONE;
                default: prod_pend <= prod_pend;
            endcase
            case ({c_out && !c_full, c_dec})
                2'b10:   chg_pend <= chg_pend + PEND_ONE;
                2'b01:   chg_pend <= chg_pend - PEND_ONE;
                default: chg_pend <= chg_pend;
            endcase
            if ((p_out && p_full) || (c_out && c_full))
                overflow <= 1'b1;
        end
    end

    // Dispense sequencer with registered actuator and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            gap_cnt   <= '0;
            motor_on  <= 1'b0;
            hopper_on <= 1'b0;
            prod_done <= 1'b0;
            chg_done  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            prod_done <= 1'b0;
            chg_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p_dec) begin
                        state    <= S_PROD;
                        timer    <= '0;
                        motor_on <= 1'b1;
                    end else if (c_dec) begin
                        state     <= S_CHG;
                        timer     <= '0;
                        hopper_on <= 1'b1;
                    end
                end
                S_PROD: begin
                    // A sense on the last window cycle still counts as success
                    if (ps) begin
                        state     <= S_GAP;
                        gap_cnt   <= '0;
                        motor_on  <= 1'b0;
                        prod_done <= 1'b1;
                    end else if (timer == MOTOR_LAST) begin
                        state    <= S_FAULT;
                        motor_on <= 1'b0;
                        fault    <= 1'b1;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                S_CHG: begin
                    if (cs) begin
                        state     <= S_GAP;
                        gap_cnt   <= '0;
                        hopper_on <= 1'b0;
                        chg_done  <= 1'b1;
                    end else if (timer == HOPPER_LAST) begin
                        state     <= S_FAULT;
                        hopper_on <= 1'b0;
                        fault     <= 1'b1;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + GAP_ONE;
                end
                S_FAULT: begin
                    // The in-flight request is gone; queued ones wait for clear
                    if (fault_clr) begin
                        state <= S_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    motor_on  <= 1'b0;
                    hopper_on <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE) || (prod_pend != '0) || (chg_pend != '0);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-count reference model.
module tb_vend_dispense_ctrl;

    localparam int PEND_W    = 3;
    localparam int MOTOR_TO  = 16;
    localparam int HOPPER_TO = 12;
    localparam int GAP_CYC   = 4;
    localparam int PMAX      = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p_out = 1'b0, c_out = 1'b0;
    logic prod_sense = 1'b0, coin_sense = 1'b0, fault_clr = 1'b0;
    logic motor_on, hopper_on, prod_done, chg_done, busy, fault, overflow;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    vend_dispense_ctrl #(
        .PEND_W(PEND_W), .MOTOR_TO(MOTOR_TO), .HOPPER_TO(HOPPER_TO), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .p_out(p_out), .c_out(c_out),
        .prod_sense(prod_sense), .coin_sense(coin_sense), .fault_clr(fault_clr),
        .motor_on(motor_on), .hopper_on(hopper_on), .prod_done(prod_done),
        .chg_done(chg_done), .busy(busy), .fault(fault), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: pending counts as integers, the running actuator,
    // how long it has run, gap cycles still owed and a fault flag.
    int m_pp = 0, m_cp = 0;
    int m_kind = 0;          // 0 none, 1 motor, 2 hopper
    int m_age = 0;           // cycles the current actuator has been on
    int m_gap_left = 0;
    bit m_faulted = 0, m_ovf = 0, m_pdone = 0, m_cdone = 0;

    always @(posedge clk) begin : mdl
        int dp, dc;
        dp = 0;
        dc = 0;
        m_pdone = 0;
        m_cdone = 0;
        if (rst) begin
            m_pp = 0; m_cp = 0; m_kind = 0; m_age = 0; m_gap_left = 0;
            m_faulted = 0; m_ovf = 0;
        end else begin
            if (m_faulted) begin
                if (fault_clr) m_faulted = 0;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (m_kind == 1) begin
                if (prod_sense) begin
                    m_pdone = 1; m_kind = 0; m_gap_left = GAP_CYC;
                end else if (m_age == MOTOR_TO) begin
                    m_kind = 0; m_faulted = 1;
                end else m_age++;
            end else if (m_kind == 2) begin
                if (coin_sense) begin
                    m_cdone = 1; m_kind = 0; m_gap_left = GAP_CYC;
                end else if (m_age == HOPPER_TO) begin
                    m_kind = 0; m_faulted = 1;
                end else m_age++;
            end else begin
                if (m_pp > 0) begin
                    m_kind = 1; m_age = 1; dp = 1;
                end else if (m_cp > 0) begin
                    m_kind = 2; m_age = 1; dc = 1;
                end
            end
            m_pp -= dp;
            m_cp -= dc;
            if (p_out) begin
                if (m_pp < PMAX) m_pp++; else m_ovf = 1;
            end
            if (c_out) begin
                if (m_cp < PMAX) m_cp++; else m_ovf = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("motor_on",  motor_on,  m_kind == 1);
            check("hopper_on", hopper_on, m_kind == 2);
            check("prod_done", prod_done, m_pdone);
            check("chg_done",  chg_done,  m_cdone);
            check("fault",     fault,     m_faulted);
            check("overflow",  overflow,  m_ovf);
            check("busy",      busy,
                  (m_kind != 0) || (m_gap_left > 0) || m_faulted || (m_pp > 0) || (m_cp > 0));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Run until idle, answering every actuator with its sensor and clearing faults
    task automatic drain(input int budget, output int npd, output int ncd);
        npd = 0;
        ncd = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            prod_sense = motor_on;
            coin_sense = hopper_on;
            fault_clr  = fault;
            if (prod_done) npd++;
            if (chg_done) ncd++;
            if (!busy) break;
        end
        prod_sense = 0; coin_sense = 0; fault_clr = 0;
        check("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int on_n, dn, gap_n, tp, tc, t, npd, ncd;
        bit counting, found;

        // Reset held two cycles
        rst = 1;
        step();
        chk_en = 1;
        step();
        check("rst_motor", motor_on, 0);  check("rst_hopper", hopper_on, 0);
        check("rst_pdone", prod_done, 0); check("rst_cdone", chg_done, 0);
        check("rst_busy", busy, 0);       check("rst_fault", fault, 0);
        check("rst_ovf", overflow, 0);
        rst = 0;
        step();

        // Single product, sensor on the 5th motor cycle
        p_out = 1; step(); p_out = 0;
        on_n = 0; dn = 0; gap_n = 0; counting = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            prod_sense = 0;
            if (motor_on) begin
                on_n++;
                if (on_n == 5) prod_sense = 1;
            end
            if (prod_done) begin dn++; counting = 1; end
            if (counting && busy) gap_n++;
            if (on_n > 0 && !busy) break;
        end
        prod_sense = 0;
        check_int("motor_cycles", on_n, 5);
        check_int("prod_done_cnt", dn, 1);
        check_int("gap_cycles", gap_n, 4);
        check("idle_after_gap", busy, 0);

        // Product and change in the same cycle
        p_out = 1; c_out = 1; step(); p_out = 0; c_out = 0;
        tp = -1; tc = -1; t = 0;
        for (int i = 0; i < 100; i++) begin
            step(); t++;
            prod_sense = motor_on;
            coin_sense = hopper_on;
            if (prod_done) tp = t;
            if (chg_done) tc = t;
            if (!busy) break;
        end
        prod_sense = 0; coin_sense = 0;
        check("both_prod_seen", tp > 0, 1);
        check_int("chg_after_prod", tc - tp, 6);

        // Change never ejects: hopper timeout then fault
        c_out = 1; step(); c_out = 0;
        on_n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (hopper_on) on_n++;
            if (fault) break;
        end
        check_int("hopper_cycles", on_n, 12);
        check("fault_set", fault, 1);
        p_out = 1; step(); p_out = 0;
        on_n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (motor_on) on_n++;
        end
        check_int("no_service_in_fault", on_n, 0);
        check("busy_in_fault", busy, 1);
        fault_clr = 1; step(); fault_clr = 0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (motor_on) begin found = 1; prod_sense = 1; break; end
        end
        check("motor_after_clr", found, 1);
        drain(100, npd, ncd);
        prod_sense = 0;

        // Eight extra requests during one long product run
        p_out = 1; step(); p_out = 0;
        for (int i = 0; i < 5 && !motor_on; i++) step();
        p_out = 1;
        repeat (8) step();
        p_out = 0;
        check("ovf_motor_still_on", motor_on, 1);
        prod_sense = 1; step(); prod_sense = 0;
        check("overflow_sticky", overflow, 1);
        drain(400, npd, ncd);
        check_int("dispenses_after_ovf", npd, 7);
        check("overflow_kept", overflow, 1);

        // Reset mid-dispense with three queued
        p_out = 1; repeat (4) step(); p_out = 0;
        for (int i = 0; i < 5 && !motor_on; i++) step();
        check("motor_before_rst", motor_on, 1);
        rst = 1; step();
        check("rst_mid_motor", motor_on, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovf", overflow, 0);
        rst = 0;
        on_n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (motor_on) on_n++;
        end
        check_int("no_dispense_after_rst", on_n, 0);

        // Randomized traffic with varying request density
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                step();
                p_out      = ($urandom_range(0, 7) < ph + 1);
                c_out      = ($urandom_range(0, 7) < ph + 1);
                prod_sense = ($urandom_range(0, 5) == 0);
                coin_sense = ($urandom_range(0, 5) == 0);
                fault_clr  = ($urandom_range(0, 9) == 0);
                rst        = ($urandom_range(0, 499) == 0);
            end
        end
        p_out = 0; c_out = 0; prod_sense = 0; coin_sense = 0; fault_clr = 0; rst = 0;
        drain(800, npd, ncd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
